// File: rtl/shared_mem_ctrl_if.sv
// Bus interface of the unified memory controller: instruction-fetch port,
// data port and the shared status outputs (busy, err).
// The core side uses the master modport, the controller the slave modport.
interface shared_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int LANES = DATA_W / 8;

    // instruction fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    // data port
    logic              d_req;
    logic              d_we;
    logic [LANES-1:0]  d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    // status
    logic              busy;
    logic              err;

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ready,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  busy, err
    );

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ready,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_ready,
        output busy, err
    );
endinterface

// File: rtl/shared_mem_ctrl.sv
// Unified single-port memory controller for the MIPS SoC.
// Arbitrates instruction-fetch and data requests onto one word array with
// byte-lane writes, WAIT programmable wait states and one-cycle ready pulses.
// Optional build macro MEM_MISALIGN_CHK_EN: flag misaligned accesses through
// err (no array access, zero read data); without it the low address bits are
// ignored and err is tied low.
module shared_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    shared_mem_ctrl_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int LBW   = (LB > 0) ? LB : 1;
    localparam int IW    = $clog2(DEPTH);

    localparam logic [3:0] WAIT_LAST = 4'((WAIT > 0) ? WAIT - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // control state
    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic              last_grant;

    // transaction latched at grant
    logic              gnt_port;
    logic [ADDR_W-1:0] a_addr;
    logic              a_we;
    logic [LANES-1:0]  a_be;
    logic [DATA_W-1:0] a_wdata;

    // response registers
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              i_ready_r;
    logic              d_ready_r;
    logic              err_r;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              any_req;
    logic              grant_data;
    logic [ADDR_W-1:0] word_addr;
    logic [IW-1:0]     idx;
    logic [LBW-1:0]    off;
    logic [DATA_W-1:0] mem_rd;
    logic              misalign;
    logic              mem_we;
    logic              unused_bits;

    // Data wins a conflict unless it won the previous grant.
    assign any_req    = bus.i_req | bus.d_req;
    assign grant_data = bus.d_req & (~bus.i_req | (last_grant == PORT_INSTR));

    // Word index wraps on the array size; upper address bits are don't-care.
    assign word_addr   = a_addr >> LB;
    assign idx         = word_addr[IW-1:0];
    assign off         = LBW'(a_addr & ADDR_W'(LANES - 1));
    assign mem_rd      = mem[idx];
    assign unused_bits = ^{word_addr, off};

`ifdef MEM_MISALIGN_CHK_EN
    // Enabled lanes must form one naturally aligned run of 2^n lanes that
    // begins at the address lane offset; an empty mask touches nothing.
    function automatic logic be_aligned(input logic [LANES-1:0] be,
                                        input logic [LBW-1:0]   lane_off);
        logic             ok;
        logic [LANES-1:0] run;
        int               o;
        int               sz;
        o  = int'(lane_off);
        ok = (be == '0);
        for (int n = 0; n <= LB; n++) begin
            sz = 1 << n;
            if (((o % sz) == 0) && ((o + sz) <= LANES)) begin
                for (int j = 0; j < LANES; j++) begin
                    run[j] = (j >= o) && (j < o + sz);
                end
                if (be == run) begin
                    ok = 1'b1;
                end
            end
        end
        return ok;
    endfunction

    assign misalign = (gnt_port == PORT_DATA) ? ~be_aligned(a_be, off)
                                              : (off != '0);
`else
    assign misalign = 1'b0;
`endif

    assign mem_we = (state == S_ACCESS) && a_we && !misalign;

    // Controller FSM, arbitration and response pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            last_grant <= PORT_INSTR;
            i_ready_r  <= 1'b0;
            d_ready_r  <= 1'b0;
            i_rdata_r  <= '0;
            d_rdata_r  <= '0;
            err_r      <= 1'b0;
        end else begin
            i_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt <= 4'd0;
                    if (any_req) begin
                        last_grant <= grant_data;
                        state      <= (WAIT > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ACCESS: begin
                    state <= S_RESP;
                    err_r <= misalign;
                    if (gnt_port == PORT_DATA) begin
                        d_ready_r <= 1'b1;
                        if (misalign) begin
                            d_rdata_r <= '0;
                        end else if (!a_we) begin
                            d_rdata_r <= mem_rd;
                        end
                    end else begin
                        i_ready_r <= 1'b1;
                        i_rdata_r <= misalign ? '0 : mem_rd;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    err_r <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the granted request so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && any_req) begin
            gnt_port <= grant_data;
            a_addr   <= grant_data ? bus.d_addr : bus.i_addr;
            a_we     <= grant_data & bus.d_we;
            a_be     <= grant_data ? bus.d_be : '1;
            a_wdata  <= bus.d_wdata;
        end
    end

    // Byte-lane write into the word array; disabled lanes keep their value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int j = 0; j < LANES; j++) begin
                if (a_be[j]) begin
                    mem[idx][8*j +: 8] <= a_wdata[8*j +: 8];
                end
            end
        end
    end

    assign bus.i_rdata = i_rdata_r;
    assign bus.i_ready = i_ready_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.d_ready = d_ready_r;
    assign bus.err     = err_r;
    assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed bench for shared_mem_ctrl: three instances built with WAIT=0, 1
// and 15 share one set of stimulus signals; sel routes requests to one of them.
module tb_shared_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          sel;
    logic        i_req_s;
    logic [31:0] i_addr_s;
    logic        d_req_s;
    logic        d_we_s;
    logic [3:0]  d_be_s;
    logic [31:0] d_addr_s;
    logic [31:0] d_wdata_s;

    int n_chk  = 0;
    int n_fail = 0;

    shared_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    shared_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    shared_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b15 ();

    assign b0.i_req    = i_req_s && (sel == 0);
    assign b0.i_addr   = i_addr_s;
    assign b0.d_req    = d_req_s && (sel == 0);
    assign b0.d_we     = d_we_s;
    assign b0.d_be     = d_be_s;
    assign b0.d_addr   = d_addr_s;
    assign b0.d_wdata  = d_wdata_s;
    assign b1.i_req    = i_req_s && (sel == 1);
    assign b1.i_addr   = i_addr_s;
    assign b1.d_req    = d_req_s && (sel == 1);
    assign b1.d_we     = d_we_s;
    assign b1.d_be     = d_be_s;
    assign b1.d_addr   = d_addr_s;
    assign b1.d_wdata  = d_wdata_s;
    assign b15.i_req   = i_req_s && (sel == 2);
    assign b15.i_addr  = i_addr_s;
    assign b15.d_req   = d_req_s && (sel == 2);
    assign b15.d_we    = d_we_s;
    assign b15.d_be    = d_be_s;
    assign b15.d_addr  = d_addr_s;
    assign b15.d_wdata = d_wdata_s;

    shared_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT(0))
        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    shared_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT(1))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    shared_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT(15))
        u15 (.clk(clk), .rst(rst), .bus(b15.slave));

    logic        i_ready_m, d_ready_m, busy_m, err_m;
    logic [31:0] i_rdata_m, d_rdata_m;

    assign i_ready_m = (sel == 0) ? b0.i_ready : (sel == 1) ? b1.i_ready : b15.i_ready;
    assign d_ready_m = (sel == 0) ? b0.d_ready : (sel == 1) ? b1.d_ready : b15.d_ready;
    assign busy_m    = (sel == 0) ? b0.busy    : (sel == 1) ? b1.busy    : b15.busy;
    assign err_m     = (sel == 0) ? b0.err     : (sel == 1) ? b1.err     : b15.err;
    assign i_rdata_m = (sel == 0) ? b0.i_rdata : (sel == 1) ? b1.i_rdata : b15.i_rdata;
    assign d_rdata_m = (sel == 0) ? b0.d_rdata : (sel == 1) ? b1.d_rdata : b15.d_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on the selected instance; starts and ends at posedge+1
    // with the controller idle. Returns the completing port's rdata and err.
    task automatic txn(input string tag, input bit dport, input logic we,
                       input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input int exp_lat,
                       output logic [31:0] rd, output logic er);
        int lat;
        int busy_low;
        bit seen;
        if (dport) begin
            d_req_s = 1'b1; d_we_s = we; d_be_s = be; d_addr_s = addr; d_wdata_s = wd;
        end else begin
            i_req_s = 1'b1; i_addr_s = addr;
        end
        lat = 0; busy_low = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!busy_m) busy_low++;
            seen = dport ? d_ready_m : i_ready_m;
        end
        rd = dport ? d_rdata_m : i_rdata_m;
        er = err_m;
        check({tag, "_other"}, dport ? i_ready_m : d_ready_m, 0);
        d_req_s = 1'b0;
        i_req_s = 1'b0;
        check({tag, "_ready"}, seen, 1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, busy_low, 0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, dport ? d_ready_m : i_ready_m, 0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          nev, cyc, stray;
    int          ev_d [4];
    int          ev_c [4];
    logic [31:0] ev_rd [4];

    initial begin
        rst = 1'b0; sel = 1;
        i_req_s = 1'b0; i_addr_s = '0; d_req_s = 1'b0; d_we_s = 1'b0;
        d_be_s = '0; d_addr_s = '0; d_wdata_s = '0;
        for (int k = 0; k < 4; k++) begin
            ev_d[k] = 0; ev_c[k] = 0; ev_rd[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_m, 0);
        check("rst_i_ready", i_ready_m, 0);
        check("rst_d_ready", d_ready_m, 0);
        check("rst_err", err_m, 0);
        check("rst_i_rdata", i_rdata_m, 0);
        check("rst_d_rdata", d_rdata_m, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // full word write / read, partial lane write, empty-mask write
        txn("wr_full", 1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 3, rd, er);
        check("wr_full_err", er, 0);
        txn("rd_full", 1, 0, 4'hF, 32'h10, 32'h0, 3, rd, er);
        check("rd_full_data", rd, 32'hDEADBEEF);
        txn("wr_b0", 1, 1, 4'h1, 32'h10, 32'h000000AA, 3, rd, er);
        check("wr_keeps_rdata", rd, 32'hDEADBEEF);
        txn("rd_b0", 1, 0, 4'hF, 32'h10, 32'h0, 3, rd, er);
        check("rd_b0_data", rd, 32'hDEADBEAA);
        txn("wr_be0", 1, 1, 4'h0, 32'h10, 32'h55555555, 3, rd, er);
        txn("rd_be0", 1, 0, 4'hF, 32'h10, 32'h0, 3, rd, er);
        check("rd_be0_data", rd, 32'hDEADBEAA);
        txn("rd_alias", 1, 0, 4'hF, 32'h1010, 32'h0, 3, rd, er);
        check("rd_alias_data", rd, 32'hDEADBEAA);
        txn("wr_arb_d", 1, 1, 4'hF, 32'h100, 32'h11111111, 3, rd, er);
        txn("wr_arb_i", 1, 1, 4'hF, 32'h200, 32'h22222222, 3, rd, er);
        txn("wr_w4", 1, 1, 4'hF, 32'h4, 32'hCAFEF00D, 3, rd, er);

`ifdef MEM_MISALIGN_CHK_EN
        txn("wr_hi_half", 1, 1, 4'hC, 32'h12, 32'h12340000, 3, rd, er);
        check("wr_hi_half_err", er, 0);
        txn("wr_mis", 1, 1, 4'h3, 32'h12, 32'h00005678, 3, rd, er);
        check("wr_mis_err", er, 1);
        check("wr_mis_rdata", rd, 0);
        txn("rd_half", 1, 0, 4'hF, 32'h10, 32'h0, 3, rd, er);
        check("rd_half_data", rd, 32'h1234BEAA);
        txn("rd_i_mis", 0, 0, 4'h0, 32'h6, 32'h0, 3, rd, er);
        check("rd_i_mis_err", er, 1);
        check("rd_i_mis_data", rd, 0);
`else
        txn("wr_mid", 1, 1, 4'h6, 32'h10, 32'h00123400, 3, rd, er);
        txn("rd_mid", 1, 0, 4'hF, 32'h10, 32'h0, 3, rd, er);
        check("rd_mid_data", rd, 32'hDE1234AA);
        txn("rd_i_off", 0, 0, 4'h0, 32'h6, 32'h0, 3, rd, er);
        check("rd_i_off_err", er, 0);
        check("rd_i_off_data", rd, 32'hCAFEF00D);
`endif

        // both ports held after an instruction grant: D, I, D, I every 4 cycles
        i_addr_s = 32'h200; d_we_s = 1'b0; d_be_s = 4'hF; d_addr_s = 32'h100;
        i_req_s = 1'b1; d_req_s = 1'b1;
        nev = 0; cyc = 0;
        while (nev < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (d_ready_m) begin
                ev_d[nev] = 1; ev_c[nev] = cyc; ev_rd[nev] = d_rdata_m; nev++;
            end else if (i_ready_m) begin
                ev_d[nev] = 0; ev_c[nev] = cyc; ev_rd[nev] = i_rdata_m; nev++;
            end
        end
        i_req_s = 1'b0; d_req_s = 1'b0;
        check("arb_events", nev, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("arb%0d_port", k), ev_d[k], (k % 2 == 0) ? 1 : 0);
            check($sformatf("arb%0d_cycle", k), ev_c[k], 3 + 4 * k);
            check($sformatf("arb%0d_data", k), ev_rd[k],
                  (k % 2 == 0) ? 32'h11111111 : 32'h22222222);
        end
        @(posedge clk); #1;

        // latency of the WAIT=0 and WAIT=15 builds
        sel = 0;
        txn("w0_wr", 1, 1, 4'hF, 32'h0, 32'h13579BDF, 2, rd, er);
        txn("w0_rd", 1, 0, 4'hF, 32'h0, 32'h0, 2, rd, er);
        check("w0_rd_data", rd, 32'h13579BDF);
        sel = 2;
        txn("w15_wr", 1, 1, 4'hF, 32'h0, 32'h2468ACE0, 17, rd, er);
        txn("w15_rd", 1, 0, 4'hF, 32'h0, 32'h0, 17, rd, er);
        check("w15_rd_data", rd, 32'h2468ACE0);

        // reset during the wait state of a write drops it
        sel = 1;
        txn("wr_old", 1, 1, 4'hF, 32'h20, 32'h0BADF00D, 3, rd, er);
        d_req_s = 1'b1; d_we_s = 1'b1; d_be_s = 4'hF; d_addr_s = 32'h20; d_wdata_s = 32'h12345678;
        @(posedge clk); #1;
        check("rstmid_busy_before", busy_m, 1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_busy", busy_m, 0);
        check("rstmid_ready", d_ready_m, 0);
        d_req_s = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        stray = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d_ready_m || i_ready_m) stray++;
        end
        check("rstmid_no_ready", stray, 0);
        txn("rd_old", 1, 0, 4'hF, 32'h20, 32'h0, 3, rd, er);
        check("rd_old_data", rd, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
